ysyx_22040750_npc_redirect: RTL and testbench

//  Parametrised next-PC generator and redirect holder between ID and the PC register.

---
 rtl/ysyx_22040750_npc_redirect_pkg.sv | 17 +
 rtl/ysyx_22040750_npc_redirect_if.sv | 29 ++
 rtl/ysyx_22040750_npc_tgt.sv | 59 +++++
 rtl/ysyx_22040750_npc_redirect.sv | 96 +++++++++
 tb/tb_ysyx_22040750_npc_redirect.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040750_npc_redirect_pkg.sv
// Shared definitions for the NPC redirect slice: I_sel bit positions, FSM encoding, default width.
// Optional build macro used by this slice: YSYX_NPC_MISALIGN_CHK_EN (see ysyx_22040750_npc_tgt).
package ysyx_22040750_pkg;

   localparam int XLEN_DEF   = 32;

   localparam int SEL_SNPC   = 0;
   localparam int SEL_JALR   = 1;
   localparam int SEL_TRAP   = 2;
   localparam int SEL_FENCEI = 3;

   typedef enum logic {
      NPC_IDLE = 1'b0,
      NPC_HOLD = 1'b1
   } npc_state_e;

endpackage

// File: rtl/ysyx_22040750_npc_redirect_if.sv
// ID-side decision bus and PC-register-side target handshake of the NPC redirect block.
// The master modport is the pipeline around the block; the slave modport is the block itself.
interface ysyx_22040750_npc_redirect_if #(
   parameter int XLEN = ysyx_22040750_pkg::XLEN_DEF
);
   logic            I_id_valid;
   logic            O_id_ready;
   logic [3:0]      I_sel;
   logic [XLEN-1:0] I_id_pc;
   logic [XLEN-1:0] I_snpc;
   logic [XLEN-1:0] I_imm;
   logic [XLEN-1:0] I_rs1_data;
   logic [XLEN-1:0] I_trap_pc;
   logic            O_dnpc_valid;
   logic            I_dnpc_ready;
   logic [XLEN-1:0] O_dnpc;
   logic            O_redirect;
   logic            O_misalign;

   modport master (
      output I_id_valid, I_sel, I_id_pc, I_snpc, I_imm, I_rs1_data, I_trap_pc, I_dnpc_ready,
      input  O_id_ready, O_dnpc_valid, O_dnpc, O_redirect, O_misalign
   );

   modport slave (
      input  I_id_valid, I_sel, I_id_pc, I_snpc, I_imm, I_rs1_data, I_trap_pc, I_dnpc_ready,
      output O_id_ready, O_dnpc_valid, O_dnpc, O_redirect, O_misalign
   );
endinterface

// File: rtl/ysyx_22040750_npc_tgt.sv
// Combinational next-PC source priority, target adders and jalr alignment.
// With YSYX_NPC_MISALIGN_CHK_EN defined, misaligned non-trap targets are replaced by the trap vector.
module ysyx_22040750_npc_tgt
   import ysyx_22040750_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ALIGN_LSB = 1
) (
   input  logic [3:0]      sel,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] snpc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] tgt,
   output logic            redirect,
   output logic            misalign
);

   function automatic logic [XLEN-1:0] align_jalr(input logic [XLEN-1:0] a);
      return a & ~((XLEN'(1) << ALIGN_LSB) - XLEN'(1));
   endfunction

   logic [XLEN-1:0] raw_tgt;
   logic            raw_redirect;

   // Trap outranks fence.i even though its select bit is lower.
   always_comb begin
      raw_tgt      = id_pc + imm;
      raw_redirect = 1'b1;
      if (sel[SEL_TRAP]) begin
         raw_tgt = trap_pc;
      end else if (sel[SEL_FENCEI]) begin
         raw_tgt = id_pc + XLEN'(4);
      end else if (sel[SEL_JALR]) begin
         raw_tgt = align_jalr(rs1_data + imm);
      end else if (sel[SEL_SNPC]) begin
         raw_tgt      = snpc;
         raw_redirect = 1'b0;
      end
   end

`ifdef YSYX_NPC_MISALIGN_CHK_EN
   function automatic logic bad_align(input logic [XLEN-1:0] t);
      return (ALIGN_LSB >= 2) ? (t[1:0] != 2'b00) : t[1];
   endfunction

   logic mis;
   assign mis      = !sel[SEL_TRAP] && bad_align(raw_tgt);
   assign tgt      = mis ? trap_pc : raw_tgt;
   assign redirect = raw_redirect | mis;
   assign misalign = mis;
`else
   assign tgt      = raw_tgt;
   assign redirect = raw_redirect;
   assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22040750_npc_redirect.sv
// Next-PC generator with a one-entry redirect holder between ID and the PC register.
// Optional misaligned-target trapping is enabled by YSYX_NPC_MISALIGN_CHK_EN (in ysyx_22040750_npc_tgt).
module ysyx_22040750_npc_redirect
   import ysyx_22040750_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ALIGN_LSB = 1
) (
   input  logic                             I_clk,
   input  logic                             I_rst,
   ysyx_22040750_npc_redirect_if.slave      bus
);

   logic [XLEN-1:0] tgt_p0;
   logic            redirect_p0;
   logic            misalign_p0;

   ysyx_22040750_npc_tgt #(
      .XLEN      (XLEN),
      .ALIGN_LSB (ALIGN_LSB)
   ) u_tgt (
      .sel      (bus.I_sel),
      .id_pc    (bus.I_id_pc),
      .snpc     (bus.I_snpc),
      .imm      (bus.I_imm),
      .rs1_data (bus.I_rs1_data),
      .trap_pc  (bus.I_trap_pc),
      .tgt      (tgt_p0),
      .redirect (redirect_p0),
      .misalign (misalign_p0)
   );

   npc_state_e      state, state_nxt;
   logic [XLEN-1:0] hold_dnpc_p1;
   logic            hold_redirect_p1;
   logic            hold_misalign_p1;
   logic            capture;
   logic            trap_ovr;
   logic            trap_in;

   assign trap_in = bus.I_id_valid && bus.I_sel[SEL_TRAP];

   always_comb begin
      state_nxt        = state;
      capture          = 1'b0;
      trap_ovr         = 1'b0;
      bus.O_id_ready   = 1'b1;
      bus.O_dnpc_valid = bus.I_id_valid;
      bus.O_dnpc       = tgt_p0;
      bus.O_redirect   = bus.I_id_valid && redirect_p0;
      bus.O_misalign   = bus.I_id_valid && misalign_p0;
      case (state)
         NPC_IDLE: begin
            if (bus.I_id_valid && !bus.I_dnpc_ready) begin
               capture   = 1'b1;
               state_nxt = NPC_HOLD;
            end
         end
         NPC_HOLD: begin
            bus.O_id_ready   = trap_in;
            bus.O_dnpc_valid = 1'b1;
            bus.O_dnpc       = hold_dnpc_p1;
            bus.O_redirect   = hold_redirect_p1;
            bus.O_misalign   = hold_misalign_p1;
            // A trap replaces the held entry even when the old one is being accepted now.
            if (trap_in) begin
               trap_ovr = 1'b1;
            end else if (bus.I_dnpc_ready) begin
               state_nxt = NPC_IDLE;
            end
         end
      endcase
   end

   // Stage p0 -> p1: hold register
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state            <= NPC_IDLE;
         hold_dnpc_p1     <= '0;
         hold_redirect_p1 <= 1'b0;
         hold_misalign_p1 <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            hold_dnpc_p1     <= tgt_p0;
            hold_redirect_p1 <= redirect_p0;
            hold_misalign_p1 <= misalign_p0;
         end else if (trap_ovr) begin
            hold_dnpc_p1     <= bus.I_trap_pc;
            hold_redirect_p1 <= 1'b1;
            hold_misalign_p1 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040750_npc_redirect.sv
// Self-checking bench for ysyx_22040750_npc_redirect: directed scenarios plus random traffic vs a queue model.
module tb_ysyx_22040750_npc_redirect;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   ysyx_22040750_npc_redirect_if #(.XLEN(32)) b1 ();
   ysyx_22040750_npc_redirect_if #(.XLEN(32)) b2 ();

   ysyx_22040750_npc_redirect #(.XLEN(32), .ALIGN_LSB(1)) u_dut1 (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (b1)
   );

   ysyx_22040750_npc_redirect #(.XLEN(32), .ALIGN_LSB(2)) u_dut2 (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (b2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [31:0] dnpc;
      logic        redir;
      logic        mis;
   } ent_t;

   ent_t held[$];

   function automatic ent_t ref_tgt(input logic [3:0] sel, input logic [31:0] pc, input logic [31:0] snpc,
                                    input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] trap,
                                    input int align);
      ent_t        e;
      logic [31:0] raw;
      logic        bad;
      e.redir = 1'b1;
      e.mis   = 1'b0;
      e.dnpc  = trap;
      if (sel[2]) return e;
      if (sel[3])      raw = pc + 32'd4;
      else if (sel[1]) begin raw = rs1 + imm; raw = (raw >> align) << align; end
      else if (sel[0]) begin raw = snpc; e.redir = 1'b0; end
      else             raw = pc + imm;
      e.dnpc = raw;
      bad = 1'b0;
`ifdef YSYX_NPC_MISALIGN_CHK_EN
      bad = (align >= 2) ? ((raw % 4) != 0) : (((raw >> 1) & 32'd1) != 0);
`endif
      if (bad) begin
         e.dnpc  = trap;
         e.redir = 1'b1;
         e.mis   = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set1(input logic v, input logic [3:0] s, input logic [31:0] pc, input logic [31:0] sn,
                       input logic [31:0] im, input logic [31:0] r1, input logic [31:0] tp, input logic rdy);
      b1.I_id_valid   = v;
      b1.I_sel        = s;
      b1.I_id_pc      = pc;
      b1.I_snpc       = sn;
      b1.I_imm        = im;
      b1.I_rs1_data   = r1;
      b1.I_trap_pc    = tp;
      b1.I_dnpc_ready = rdy;
   endtask

   // Settle, then compare DUT1 outputs with the model.
   task automatic eval1();
      ent_t        e;
      logic        ev, er, em, eir;
      logic [31:0] ed;
      #1;
      e = ref_tgt(b1.I_sel, b1.I_id_pc, b1.I_snpc, b1.I_imm, b1.I_rs1_data, b1.I_trap_pc, 1);
      if (held.size() != 0) begin
         ev  = 1'b1;
         ed  = held[0].dnpc;
         er  = held[0].redir;
         em  = held[0].mis;
         eir = b1.I_id_valid && b1.I_sel[2];
      end else begin
         ev  = b1.I_id_valid;
         ed  = e.dnpc;
         er  = ev && e.redir;
         em  = ev && e.mis;
         eir = 1'b1;
      end
      chk("m_valid",    32'(b1.O_dnpc_valid), 32'(ev));
      chk("m_id_ready", 32'(b1.O_id_ready),   32'(eir));
      chk("m_redirect", 32'(b1.O_redirect),   32'(er));
      chk("m_misalign", 32'(b1.O_misalign),   32'(em));
      if (ev) chk("m_dnpc", b1.O_dnpc, ed);
   endtask

   // Clock edge: advance the model with the inputs the DUT sampled.
   task automatic tick1();
      ent_t e;
      @(posedge clk);
      e = ref_tgt(b1.I_sel, b1.I_id_pc, b1.I_snpc, b1.I_imm, b1.I_rs1_data, b1.I_trap_pc, 1);
      if (rst) begin
         held.delete();
      end else if (held.size() != 0) begin
         if (b1.I_id_valid && b1.I_sel[2]) held[0] = '{b1.I_trap_pc, 1'b1, 1'b0};
         else if (b1.I_dnpc_ready)         void'(held.pop_front());
      end else if (b1.I_id_valid && !b1.I_dnpc_ready) begin
         held.push_back(e);
      end
      @(negedge clk);
   endtask

   localparam logic [31:0] TRAP = 32'h8000_0800;

   initial begin
      logic [31:0] exp2;
      logic        exp2_mis;
      logic [31:0] exp6;
      logic        exp6_mis;
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      set1(1'b0, 4'b0000, '0, '0, '0, '0, '0, 1'b0);
      b2.I_id_valid = 1'b0; b2.I_sel = 4'b0000; b2.I_id_pc = '0; b2.I_snpc = '0;
      b2.I_imm = '0; b2.I_rs1_data = '0; b2.I_trap_pc = '0; b2.I_dnpc_ready = 1'b1;
      @(negedge clk);
      eval1();
      tick1();
      rst = 1'b0;

      // Reset state
      eval1();
      chk("rst_valid",    32'(b1.O_dnpc_valid), 32'd0);
      chk("rst_redirect", 32'(b1.O_redirect),   32'd0);
      chk("rst_id_ready", 32'(b1.O_id_ready),   32'd1);
      tick1();

      // 1: snpc pass-through
      set1(1'b1, 4'b0001, 32'h8000_0000, 32'h8000_0004, '0, '0, TRAP, 1'b1);
      eval1();
      chk("t1_dnpc",     b1.O_dnpc,               32'h8000_0004);
      chk("t1_redirect", 32'(b1.O_redirect),      32'd0);
      chk("t1_valid",    32'(b1.O_dnpc_valid),    32'd1);
      tick1();
      set1(1'b0, 4'b0000, '0, '0, '0, '0, TRAP, 1'b0);
      eval1();
      chk("t1_idle", 32'(b1.O_id_ready), 32'd1);
      tick1();

      // 2: jalr held for three stalled cycles
`ifdef YSYX_NPC_MISALIGN_CHK_EN
      exp2 = TRAP;           exp2_mis = 1'b1;
`else
      exp2 = 32'h8000_1006;  exp2_mis = 1'b0;
`endif
      set1(1'b1, 4'b0010, 32'h8000_1000, 32'h8000_1004, 32'd4, 32'h8000_1003, TRAP, 1'b0);
      for (int i = 0; i < 4; i++) begin
         b1.I_dnpc_ready = (i == 3);
         eval1();
         chk("t2_dnpc",     b1.O_dnpc,            exp2);
         chk("t2_misalign", 32'(b1.O_misalign),   32'(exp2_mis));
         chk("t2_id_ready", 32'(b1.O_id_ready),   32'(i == 0));
         tick1();
      end
      set1(1'b0, 4'b0000, '0, '0, '0, '0, TRAP, 1'b0);
      eval1();
      chk("t2_done", 32'(b1.O_dnpc_valid), 32'd0);
      tick1();

      // 3: trap overrides a stalled jal target
      set1(1'b1, 4'b0000, 32'h8000_0000, 32'h8000_0004, 32'h100, '0, TRAP, 1'b0);
      eval1(); tick1();
      set1(1'b1, 4'b0100, 32'h8000_0000, 32'h8000_0004, 32'h100, '0, TRAP, 1'b0);
      eval1();
      chk("t3_old_dnpc", b1.O_dnpc,             32'h8000_0100);
      chk("t3_id_ready", 32'(b1.O_id_ready),    32'd1);
      tick1();
      set1(1'b0, 4'b0000, '0, '0, '0, '0, TRAP, 1'b0);
      eval1();
      chk("t3_dnpc",     b1.O_dnpc,             TRAP);
      chk("t3_redirect", 32'(b1.O_redirect),    32'd1);
      chk("t3_valid",    32'(b1.O_dnpc_valid),  32'd1);
      tick1();
      b1.I_dnpc_ready = 1'b1;
      eval1(); tick1();
      b1.I_dnpc_ready = 1'b0;
      eval1();
      chk("t3_idle", 32'(b1.O_dnpc_valid), 32'd0);
      tick1();

      // 4: trap and accept in the same cycle
      set1(1'b1, 4'b0000, 32'h8000_0000, 32'h8000_0004, 32'h100, '0, TRAP, 1'b0);
      eval1(); tick1();
      set1(1'b1, 4'b0100, 32'h8000_0000, 32'h8000_0004, 32'h100, '0, TRAP, 1'b1);
      eval1();
      chk("t4_accepted", b1.O_dnpc, 32'h8000_0100);
      tick1();
      set1(1'b0, 4'b0000, '0, '0, '0, '0, TRAP, 1'b0);
      eval1();
      chk("t4_trap_dnpc",  b1.O_dnpc,            TRAP);
      chk("t4_trap_valid", 32'(b1.O_dnpc_valid), 32'd1);
      chk("t4_id_ready",   32'(b1.O_id_ready),   32'd0);
      tick1();
      b1.I_dnpc_ready = 1'b1;
      eval1(); tick1();

      // 5: reset while holding
      set1(1'b1, 4'b0000, 32'h8000_0000, 32'h8000_0004, 32'h100, '0, TRAP, 1'b0);
      eval1(); tick1();
      set1(1'b0, 4'b0000, '0, '0, '0, '0, TRAP, 1'b0);
      rst = 1'b1;
      eval1(); tick1();
      rst = 1'b0;
      eval1();
      chk("t5_valid",    32'(b1.O_dnpc_valid), 32'd0);
      chk("t5_redirect", 32'(b1.O_redirect),   32'd0);
      chk("t5_id_ready", 32'(b1.O_id_ready),   32'd1);
      tick1();

      // Priority with several select bits set
      set1(1'b1, 4'b1111, 32'h8000_0000, 32'h8000_0004, 32'h10, 32'h8000_2000, TRAP, 1'b1);
      eval1();
      chk("prio_trap", b1.O_dnpc, TRAP);
      tick1();
      set1(1'b1, 4'b1010, 32'h8000_0000, 32'h8000_0004, 32'h10, 32'h8000_2000, TRAP, 1'b1);
      eval1();
      chk("prio_fencei", b1.O_dnpc, 32'h8000_0004);
      tick1();
      set1(1'b1, 4'b0011, 32'h8000_0000, 32'h8000_0004, 32'h10, 32'h8000_2000, TRAP, 1'b1);
      eval1();
      chk("prio_jalr", b1.O_dnpc, 32'h8000_2010);
      tick1();

      // 6: ALIGN_LSB=2 instance, jal to a half-word target
`ifdef YSYX_NPC_MISALIGN_CHK_EN
      exp6 = TRAP;           exp6_mis = 1'b1;
`else
      exp6 = 32'h8000_0002;  exp6_mis = 1'b0;
`endif
      b2.I_id_valid = 1'b1; b2.I_sel = 4'b0000; b2.I_id_pc = 32'h8000_0000;
      b2.I_imm = 32'h2; b2.I_trap_pc = TRAP; b2.I_dnpc_ready = 1'b1;
      #1;
      chk("t6_dnpc",     b2.O_dnpc,           exp6);
      chk("t6_misalign", 32'(b2.O_misalign),  32'(exp6_mis));
      chk("t6_redirect", 32'(b2.O_redirect),  32'd1);
      b2.I_id_valid = 1'b0;
      @(negedge clk);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc;
         pc = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) pc = pc | 32'h2;
         set1($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pc,
              ($urandom_range(0, 3) == 0) ? $urandom : pc + 32'd4,
              32'($urandom_range(0, 1023)) - 32'd512, $urandom,
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 49) == 0);
         eval1();
         tick1();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
